// File: rtl/ctrl_pipe_chain.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_chain
//
// Purpose
//   Control-word pipeline for the ID->EX->MEM->WB control path. Each of the
//   STAGES registers carries a decoded control word, a valid bit and a halt
//   bit. A stall holds stage 0 and drops a real bubble into stage 1. This
//   means a held instruction is never duplicated downstream. A flush clears
//   the FLUSH_DEPTH youngest stages. A HALT that leaves the last stage sets a
//   sticky halted flag. A saturating counter records cycles in which the last
//   stage was empty while the core was still running.
//
// Parameters
//   CTRL_W       width of the control word
//   STAGES       number of pipeline registers (>= 2)
//   FLUSH_DEPTH  number of youngest stages cleared by flush (1..STAGES)
//   CNT_W        width of the bubble counter
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous reset, active low
//   in_valid     in   control word present at the input
//   in_ctrl      in   decoded control word
//   in_halt      in   input instruction is HALT
//   stall        in   hold stage 0, bubble into stage 1
//   flush        in   clear stages 0..FLUSH_DEPTH-1
//   in_ready     out  input can be taken (no halt pending or retired)
//   stage_valid  out  valid bit per stage, bit k = stage k
//   stage_ctrl   out  control words, stage k at [k*CTRL_W +: CTRL_W]
//   occupancy    out  number of valid stages
//   halted       out  HALT has retired from the last stage (sticky)
//   bubble_cnt   out  saturating count of empty last-stage cycles
// ----------------------------------------------------------------------------
module ctrl_pipe_chain #(
    parameter int CTRL_W      = 16,
    parameter int STAGES      = 3,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic                         in_halt,
    input  logic                         stall,
    input  logic                         flush,
    output logic                         in_ready,
    output logic [STAGES-1:0]            stage_valid,
    output logic [STAGES*CTRL_W-1:0]     stage_ctrl,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic                         halted,
    output logic [CNT_W-1:0]             bubble_cnt
);

    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int LAST  = STAGES - 1;

    // Pipeline state. The packed layout of ctrl_q matches the flattened
    // stage_ctrl port directly.
    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0]             halt_q,  halt_d;
    logic [STAGES-1:0][CTRL_W-1:0] ctrl_q,  ctrl_d;

    logic                          halted_q, halted_d;
    logic [CNT_W-1:0]              bubble_q, bubble_d;

    logic                          halt_pending;
    logic                          accept;
    logic [OCC_W-1:0]              occ_sum;

    // ------------------------------------------------------------------
    // Input handshake
    // ------------------------------------------------------------------
    // A halt anywhere in flight closes the input. Flushing that halt away
    // reopens the input on the following cycle.
    assign halt_pending = |(valid_q & halt_q);
    assign in_ready     = !halted_q && !halt_pending;
    assign accept       = in_valid && in_ready && !stall && !flush;

    // ------------------------------------------------------------------
    // Per-stage next state
    // ------------------------------------------------------------------
    // An invalid stage always carries ctrl=0 and halt=0. Loads are gated
    // by accept and every clear forces zero. A bubble therefore can never
    // assert a write enable downstream.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // Priority: flush clears, then stall holds, then load or bubble.
                assign valid_d[0] = flush ? 1'b0
                                  : (stall ? valid_q[0] : accept);
                assign halt_d[0]  = flush ? 1'b0
                                  : (stall ? halt_q[0] : (accept & in_halt));
                assign ctrl_d[0]  = flush ? {CTRL_W{1'b0}}
                                  : (stall ? ctrl_q[0]
                                           : (accept ? in_ctrl : {CTRL_W{1'b0}}));
            end else begin : g_body
                // Stage 1 is the one that takes the stall bubble. The older
                // stages keep draining during a stall. Flush only reaches the
                // youngest FLUSH_DEPTH stages.
                localparam bit FLUSHED      = (gi < FLUSH_DEPTH);
                localparam bit STALL_BUBBLE = (gi == 1);

                logic kill;
                assign kill = (FLUSHED && flush) || (STALL_BUBBLE && stall);

                assign valid_d[gi] = kill ? 1'b0 : valid_q[gi-1];
                assign halt_d[gi]  = kill ? 1'b0 : halt_q[gi-1];
                assign ctrl_d[gi]  = kill ? {CTRL_W{1'b0}} : ctrl_q[gi-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Retirement status and performance counter
    // ------------------------------------------------------------------
    assign halted_d = halted_q || (valid_q[LAST] && halt_q[LAST]);

    always_comb begin
        bubble_d = bubble_q;
        if (!valid_q[LAST] && !halted_q && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q  <= '0;
            halt_q   <= '0;
            ctrl_q   <= '0;
            halted_q <= 1'b0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            halt_q   <= halt_d;
            ctrl_q   <= ctrl_d;
            halted_q <= halted_d;
            bubble_q <= bubble_d;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy: popcount of the valid bits
    // ------------------------------------------------------------------
    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_sum = occ_sum + OCC_W'(valid_q[i]);
        end
    end

    assign stage_valid = valid_q;
    assign stage_ctrl  = ctrl_q;
    assign occupancy   = occ_sum;
    assign halted      = halted_q;
    assign bubble_cnt  = bubble_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// ----------------------------------------------------------------------------
// tb_ctrl_pipe_chain
//
// This bench drives three instances of ctrl_pipe_chain from one shared set of
// inputs:
//   a_*  STAGES=3, FLUSH_DEPTH=1, CNT_W=16 (the primary instance)
//   b_*  FLUSH_DEPTH=2
//   c_*  CNT_W=4
// Expected retirements of the primary instance are queued when the stimulus
// is issued. A monitor pops and compares one entry each time the last stage
// shows a valid word. Stage contents and status are checked directly against
// hand-computed constants.
// ----------------------------------------------------------------------------
module tb_ctrl_pipe_chain;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_ctrl = 16'h0000;
    logic        in_halt = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        a_ready, b_ready, c_ready;
    logic [2:0]  a_valid, b_valid, c_valid;
    logic [47:0] a_ctrl,  b_ctrl,  c_ctrl;
    logic [1:0]  a_occ,   b_occ,   c_occ;
    logic        a_halted, b_halted, c_halted;
    logic [15:0] a_bub,   b_bub;
    logic [3:0]  c_bub;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    always #5 clk = ~clk;

    ctrl_pipe_chain #(.CTRL_W(16), .STAGES(3), .FLUSH_DEPTH(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_halt(in_halt), .stall(stall), .flush(flush), .in_ready(a_ready),
        .stage_valid(a_valid), .stage_ctrl(a_ctrl), .occupancy(a_occ),
        .halted(a_halted), .bubble_cnt(a_bub)
    );

    ctrl_pipe_chain #(.CTRL_W(16), .STAGES(3), .FLUSH_DEPTH(2), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_halt(in_halt), .stall(stall), .flush(flush), .in_ready(b_ready),
        .stage_valid(b_valid), .stage_ctrl(b_ctrl), .occupancy(b_occ),
        .halted(b_halted), .bubble_cnt(b_bub)
    );

    ctrl_pipe_chain #(.CTRL_W(16), .STAGES(3), .FLUSH_DEPTH(1), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_halt(in_halt), .stall(stall), .flush(flush), .in_ready(c_ready),
        .stage_valid(c_valid), .stage_ctrl(c_ctrl), .occupancy(c_occ),
        .halted(c_halted), .bubble_cnt(c_bub)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one line per retired word of the primary instance.
    always @(negedge clk) begin
        if (reset && a_valid[2]) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL retire: got 0x%04h, expected no retirement", a_ctrl[47:32]);
            end else begin
                mon_exp = exp_q.pop_front();
                if (a_ctrl[47:32] !== mon_exp) begin
                    errors++;
                    $display("FAIL retire: got 0x%04h, expected 0x%04h", a_ctrl[47:32], mon_exp);
                end else begin
                    $display("retire ctrl=0x%04h ok", a_ctrl[47:32]);
                end
            end
        end
    end

    initial begin
        // ---- 1. reset held with a live input -------------------------
        reset = 1'b0; in_valid = 1'b1; in_ctrl = 16'hFFFF;
        tick(); tick();
        chk("rst_valid",  64'(a_valid),  64'h0);
        chk("rst_ctrl",   64'(a_ctrl),   64'h0);
        chk("rst_halted", 64'(a_halted), 64'h0);
        chk("rst_bubble", 64'(a_bub),    64'h0);
        chk("rst_ready",  64'(a_ready),  64'h1);
        chk("rst_occ",    64'(a_occ),    64'h0);
        reset = 1'b1; in_valid = 1'b0; in_ctrl = 16'h0000;

        // ---- 2. stream three words -----------------------------------
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_ctrl = 16'(i);
            exp_q.push_back(16'(i));
            tick();
        end
        chk("stream_valid", 64'(a_valid), 64'h7);
        chk("stream_ctrl",  64'(a_ctrl),  64'h0001_0002_0003);
        chk("stream_occ",   64'(a_occ),   64'h3);
        in_valid = 1'b0;
        tick(); tick(); tick();

        // ---- 3. accept then stall two cycles -------------------------
        in_valid = 1'b1; in_ctrl = 16'h00A5;
        exp_q.push_back(16'h00A5);
        tick();
        stall = 1'b1; in_ctrl = 16'h00EE;   // offered but must not be taken
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_s0_valid", 64'(a_valid[0]),      64'h1);
            chk("stall_s0_ctrl",  64'(a_ctrl[15:0]),    64'h00A5);
            chk("stall_s1_valid", 64'(a_valid[1]),      64'h0);
            chk("stall_s1_ctrl",  64'(a_ctrl[31:16]),   64'h0);
        end
        stall = 1'b0; in_valid = 1'b0;
        tick();
        chk("unstall_valid", 64'(a_valid), 64'h2);
        chk("unstall_ctrl",  64'(a_ctrl),  64'h0000_00A5_0000);
        tick();
        chk("a5_at_s2", 64'(a_valid), 64'h4);
        tick();
        chk("a5_gone",  64'(a_valid), 64'h0);

        // ---- 4. flush together with stall ----------------------------
        in_valid = 1'b1; in_ctrl = 16'h0022;
        exp_q.push_back(16'h0022);
        tick();
        in_ctrl = 16'h0011;                  // will be flushed
        tick();
        flush = 1'b1; stall = 1'b1; in_ctrl = 16'h0033;
        tick();
        chk("fs_a_valid", 64'(a_valid), 64'h4);
        chk("fs_a_ctrl",  64'(a_ctrl),  64'h0022_0000_0000);
        chk("fs_b_valid", 64'(b_valid), 64'h4);
        chk("fs_b_ctrl",  64'(b_ctrl),  64'h0022_0000_0000);
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        tick(); tick();

        // flush alone: depth 1 lets s0 move on, depth 2 also kills stage 1
        in_valid = 1'b1; in_ctrl = 16'h0022;
        exp_q.push_back(16'h0022);
        tick();
        in_ctrl = 16'h0011;
        exp_q.push_back(16'h0011);
        tick();
        flush = 1'b1; in_ctrl = 16'h0033;
        tick();
        chk("f_a_valid", 64'(a_valid), 64'h6);
        chk("f_a_ctrl",  64'(a_ctrl),  64'h0022_0011_0000);
        chk("f_a_occ",   64'(a_occ),   64'h2);
        chk("f_b_valid", 64'(b_valid), 64'h4);
        chk("f_b_ctrl",  64'(b_ctrl),  64'h0022_0000_0000);
        chk("f_b_occ",   64'(b_occ),   64'h1);
        flush = 1'b0; in_valid = 1'b0;
        tick(); tick(); tick();

        // ---- 5a. halt retires ----------------------------------------
        in_valid = 1'b1; in_ctrl = 16'h0F00; in_halt = 1'b1;
        exp_q.push_back(16'h0F00);
        tick();                              // E1
        chk("halt_ready_e1", 64'(a_ready), 64'h0);
        in_ctrl = 16'h0BAD; in_halt = 1'b0;  // still offered, must be ignored
        tick();                              // E2
        chk("halt_e2_valid", 64'(a_valid), 64'h2);
        chk("halt_e2_ready", 64'(a_ready), 64'h0);
        tick();                              // E3: halt sits in the last stage
        chk("halt_e3_ctrl",   64'(a_ctrl),   64'h0F00_0000_0000);
        chk("halt_e3_halted", 64'(a_halted), 64'h0);
        tick();                              // E4: retired
        chk("halt_e4_halted", 64'(a_halted), 64'h1);
        chk("halt_e4_valid",  64'(a_valid),  64'h0);
        chk("halt_e4_ready",  64'(a_ready),  64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_sticky", 64'(a_halted), 64'h1);
            chk("halt_drain",  64'(a_valid),  64'h0);
        end
        in_valid = 1'b0;

        // ---- 5b. halt flushed out of stage 0 -------------------------
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        in_valid = 1'b1; in_ctrl = 16'h0F00; in_halt = 1'b1;
        tick();                              // E1
        in_valid = 1'b0; in_halt = 1'b0;
        chk("hflush_ready_e1", 64'(a_ready), 64'h0);
        // Stall with the flush so the depth-1 instance also drops stage 0.
        flush = 1'b1; stall = 1'b1;
        tick();                              // E2
        flush = 1'b0; stall = 1'b0;
        chk("hflush_a_ready", 64'(a_ready), 64'h1);
        chk("hflush_b_ready", 64'(b_ready), 64'h1);
        chk("hflush_a_valid", 64'(a_valid), 64'h0);
        tick(); tick(); tick(); tick();
        chk("hflush_a_halted", 64'(a_halted), 64'h0);
        chk("hflush_b_halted", 64'(b_halted), 64'h0);
        in_valid = 1'b1; in_ctrl = 16'h0077;
        exp_q.push_back(16'h0077);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();

        // ---- 6. bubble counter saturation and mid-stream reset -------
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("bub_c4_10", 64'(c_bub), 64'd10);
        for (int i = 0; i < 10; i++) tick();
        chk("bub_c4_sat", 64'(c_bub), 64'd15);
        chk("bub_a_20",   64'(a_bub), 64'd20);
        in_valid = 1'b1; in_ctrl = 16'h0055;
        tick();
        in_ctrl = 16'h0066;
        tick();
        chk("mid_valid", 64'(a_valid), 64'h3);
        chk("mid_ctrl",  64'(a_ctrl),  64'h0000_0055_0066);
        reset = 1'b0; stall = 1'b1; in_halt = 1'b1; in_ctrl = 16'hFFFF;
        tick();
        chk("mrst_a_valid",  64'(a_valid),  64'h0);
        chk("mrst_a_ctrl",   64'(a_ctrl),   64'h0);
        chk("mrst_a_bub",    64'(a_bub),    64'h0);
        chk("mrst_a_ready",  64'(a_ready),  64'h1);
        chk("mrst_a_halted", 64'(a_halted), 64'h0);
        chk("mrst_a_occ",    64'(a_occ),    64'h0);
        chk("mrst_b_valid",  64'(b_valid),  64'h0);
        chk("mrst_c_bub",    64'(c_bub),    64'h0);
        chk("mrst_c_ctrl",   64'(c_ctrl),   64'h0);
        reset = 1'b1; stall = 1'b0; in_valid = 1'b0; in_halt = 1'b0; in_ctrl = 16'h0000;
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending retirements, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
